fll_cfg_ctrl: RTL and testbench
===============================

# fll_cfg_ctrl

Configuration sequencer for the FLL macro inside the clock/reset generator. After reset it replays two boot configuration words into the FLL over its four-phase req/ack config port. It then waits for lock and drives the reference/FLL clock-mux select. From then on it serves runtime register accesses from a single bus-side requester and falls back to the reference clock on loss of lock.

## Interface
Parameters:
- BOOT_EN, 1: 1 = run the boot sequence after reset; 0 = go straight to IDLE.
- BOOT_CFG1, 32'h0000_0000: data written to FLL address 2'd1 during boot.
- BOOT_CFG2, 32'h0000_0000: data written to FLL address 2'd2 during boot.
- LOCK_TIMEOUT, 4096: maximum cycles spent in LOCK.
- ACK_TIMEOUT, 64: maximum cycles spent in each of REQ and REL.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, synchronous, active-high.
- cfg_req_i, in, 1: bus access request.
- cfg_we_i, in, 1: 1 = write.
- cfg_addr_i, in, 2: FLL register address.
- cfg_wdata_i, in, 32: write data.
- cfg_relock_i, in, 1: single-cycle pulse; re-enter LOCK.
- cfg_gnt_o, out, 1: command accepted.
- cfg_rvalid_o, out, 1: one-cycle completion strobe.
- cfg_rdata_o, out, 32: read data; 0 for writes.
- cfg_err_o, out, 1: qualifies cfg_rvalid_o; ack timeout.
- fll_req_o, out, 1: FLL config request.
- fll_wrn_o, out, 1: FLL write-not (0 = write).
- fll_add_o, out, 2: FLL config address.
- fll_data_o, out, 32: FLL config data.
- fll_ack_i, in, 1: FLL ack; may be asynchronous.
- fll_r_data_i, in, 32: FLL read data; stable while ack is high.
- fll_lock_i, in, 1: FLL lock; may be asynchronous.
- clk_sel_o, out, 1: 1 = select FLL clock.
- boot_done_o, out, 1: boot sequence finished (sticky).
- lock_err_o, out, 1: sticky; lock timeout or lock lost.

## Operation
- Synchronizers: fll_ack_i and fll_lock_i each pass through a 2-flop synchronizer, giving ack_s and lock_s. The FSM uses only ack_s and lock_s.
- FSM states: BOOT, REQ, REL, LOCK, IDLE, RESP. A 1-bit boot index selects the BOOT_CFG1 or BOOT_CFG2 word.
- BOOT: load the command {wrn=0, add=1 or 2, data=BOOT_CFGx} and go to REQ.
- REQ: fll_req_o=1, with add/data/wrn held stable. On ack_s=1, capture fll_r_data_i (reads only) and go to REL.
- REL: fll_req_o=0. On ack_s=0, leave REL:
  - boot, index 0 -> BOOT with index 1;
  - boot, index 1 -> LOCK;
  - otherwise -> RESP.
- Ack timeout: a cycle counter is cleared on entry to REQ and on entry to REL. Reaching ACK_TIMEOUT aborts the transaction with fll_req_o dropped:
  - bus access -> RESP with cfg_err_o=1;
  - boot -> IDLE with boot_done_o=1 and lock_err_o=1.
- LOCK: a counter runs from 0.
  - lock_s=1 -> clk_sel_o=1, boot_done_o=1, go to IDLE.
  - Counter reaches LOCK_TIMEOUT -> lock_err_o=1, boot_done_o=1, clk_sel_o stays 0, go to IDLE.
- IDLE:
  - cfg_gnt_o = cfg_req_i & ~ack_s & ~cfg_relock_i (combinational).
  - On a grant, latch {~cfg_we_i, cfg_addr_i, cfg_wdata_i} and go to REQ.
  - cfg_relock_i in IDLE -> LOCK. Relock takes priority over a simultaneous cfg_req_i.
  - cfg_relock_i outside IDLE is ignored.
- RESP: cfg_rvalid_o=1 for one cycle; then go to IDLE.
- Loss of lock: in any state, clk_sel_o=1 and lock_s=0 -> clk_sel_o=0 next cycle, lock_err_o=1. The current FSM state continues unaffected.
- lock_err_o clears only on reset.
- With BOOT_EN=0, the reset state is IDLE with boot_done_o=1.
- A synchronous reset mid-transaction returns the FSM to BOOT (or IDLE if BOOT_EN=0) and drops fll_req_o the next cycle. An ack still high afterwards blocks grants until ack_s is 0.

## Timing
- Reset values: every output 0, except boot_done_o = ~BOOT_EN.
- All outputs are registered except cfg_gnt_o.
- fll_add_o, fll_data_o and fll_wrn_o change only when entering REQ.
- Loopback FLL model (ack = req): one transaction takes REQ 3 cycles + REL 3 cycles.
- Bus access, grant in cycle g:
  - fll_req_o high in cycles g+1 to g+3;
  - cfg_rvalid_o in cycle g+7;
  - next grant possible in cycle g+8.
- Boot, reset released before cycle 0:
  - REQ in cycles 1-3 and 8-10;
  - LOCK entered at cycle 14;
  - clk_sel_o rises 3 cycles after fll_lock_i rises (2 sync stages + 1 register).
- Counters saturate. Widths are $clog2(timeout)+1.

## Test plan
- Boot with loopback ack, BOOT_CFG1=32'h1234_5678, BOOT_CFG2=32'hCAFE_0001, lock raised at cycle 20:
  - two writes observed, to add 1 then add 2, with matching data;
  - clk_sel_o=1 and boot_done_o=1 at cycle 23.
- Lock never asserted, LOCK_TIMEOUT=16:
  - lock_err_o=1 and boot_done_o=1 at cycle 30; clk_sel_o stays 0.
- Bus read of addr 3 with fll_r_data_i=32'hDEAD_BEEF:
  - rvalid 7 cycles after grant, rdata=32'hDEAD_BEEF, err=0.
- Ack tied low, ACK_TIMEOUT=8, bus write:
  - fll_req_o high for 8 cycles, then rvalid with cfg_err_o=1.
- Lock drops in IDLE:
  - clk_sel_o falls 3 cycles later and lock_err_o=1.
  - A cfg_relock_i pulse with lock restored -> clk_sel_o=1 again.
- rst_i asserted in REQ of a bus access:
  - fll_req_o=0 the next cycle; all outputs at reset values; boot restarts.

Source files
------------

// File: rtl/fll_cfg_ctrl.sv
// fll_cfg_ctrl: replays boot words into the FLL over its four-phase config port, waits for
// lock to drive the reference/FLL clock mux, then serves runtime bus accesses to FLL registers.
module fll_cfg_ctrl #(
    parameter bit          BOOT_EN      = 1'b1,
    parameter logic [31:0] BOOT_CFG1    = 32'h0000_0000,
    parameter logic [31:0] BOOT_CFG2    = 32'h0000_0000,
    parameter int          LOCK_TIMEOUT = 4096,
    parameter int          ACK_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_req_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    input  logic        cfg_relock_i,
    output logic        cfg_gnt_o,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        cfg_err_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        clk_sel_o,
    output logic        boot_done_o,
    output logic        lock_err_o
);

    localparam int LCNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int ACNT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [LCNT_W-1:0] LOCK_MAX  = LCNT_W'(LOCK_TIMEOUT);
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [ACNT_W-1:0] ACK_MAX   = ACNT_W'(ACK_TIMEOUT);
    localparam logic [ACNT_W-1:0] ACK_LAST  = ACNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT, S_REQ, S_REL, S_LOCK, S_IDLE, S_RESP
    } state_t;

    state_t            state, state_d;
    logic              ack_p0, ack_s, lock_p0, lock_s;
    logic [ACNT_W-1:0] ack_cnt;
    logic [LCNT_W-1:0] lock_cnt;
    logic              boot_idx;
    logic [31:0]       rd_cap;
    logic              ack_to, lock_to, ack_abort, in_boot;
    logic              load_cmd, cmd_wrn;
    logic [1:0]        cmd_add;
    logic [31:0]       cmd_data, rdata_d;
    logic              rvalid_d, err_d, csel_d, bd_d, le_d;

    // ack and lock come from the FLL clock domain: two flops each before any use
    always_ff @(posedge clk_i) begin
        ack_p0  <= fll_ack_i;
        ack_s   <= ack_p0;
        lock_p0 <= fll_lock_i;
        lock_s  <= lock_p0;
    end

    assign ack_to    = (ack_cnt >= ACK_LAST);
    assign lock_to   = (lock_cnt >= LOCK_LAST);
    assign in_boot   = ~boot_done_o;
    assign ack_abort = ack_to && ((state == S_REQ && !ack_s) || (state == S_REL && ack_s));
    assign cfg_gnt_o = (state == S_IDLE) && cfg_req_i && !ack_s && !cfg_relock_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (BOOT_EN) state <= S_BOOT;
            else         state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            // a stale ack left over from an interrupted handshake must drain before a new request
            S_BOOT: if (!ack_s) state_d = S_REQ;
            S_REQ: begin
                if (ack_s)       state_d = S_REL;
                else if (ack_to) state_d = in_boot ? S_IDLE : S_RESP;
            end
            S_REL: begin
                if (!ack_s)      state_d = in_boot ? (boot_idx ? S_LOCK : S_BOOT) : S_RESP;
                else if (ack_to) state_d = in_boot ? S_IDLE : S_RESP;
            end
            S_LOCK: if (lock_s || lock_to) state_d = S_IDLE;
            S_IDLE: begin
                if (cfg_relock_i)   state_d = S_LOCK;
                else if (cfg_gnt_o) state_d = S_REQ;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_cmd = (state_d == S_REQ) && (state != S_REQ);
        cmd_wrn  = 1'b0;
        cmd_add  = boot_idx ? 2'd2 : 2'd1;
        cmd_data = boot_idx ? BOOT_CFG2 : BOOT_CFG1;
        if (state == S_IDLE) begin
            cmd_wrn  = ~cfg_we_i;
            cmd_add  = cfg_addr_i;
            cmd_data = cfg_wdata_i;
        end
        rvalid_d = (state_d == S_RESP);
        err_d    = rvalid_d && ack_abort;
        rdata_d  = (rvalid_d && !ack_abort) ? rd_cap : 32'h0;
        csel_d   = clk_sel_o;
        if (state == S_LOCK && lock_s) csel_d = 1'b1;
        else if (!lock_s)              csel_d = 1'b0;
        le_d = lock_err_o || (clk_sel_o && !lock_s) ||
               (state == S_LOCK && !lock_s && lock_to) || (ack_abort && in_boot);
        bd_d = boot_done_o || (state == S_LOCK && state_d == S_IDLE) || (ack_abort && in_boot);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fll_req_o    <= 1'b0;
            fll_wrn_o    <= 1'b0;
            fll_add_o    <= 2'd0;
            fll_data_o   <= 32'h0;
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= 32'h0;
            clk_sel_o    <= 1'b0;
            boot_done_o  <= !BOOT_EN;
            lock_err_o   <= 1'b0;
            boot_idx     <= 1'b0;
            ack_cnt      <= '0;
            lock_cnt     <= '0;
        end else begin
            fll_req_o <= (state_d == S_REQ);
            if (load_cmd) begin
                fll_wrn_o  <= cmd_wrn;
                fll_add_o  <= cmd_add;
                fll_data_o <= cmd_data;
            end
            cfg_rvalid_o <= rvalid_d;
            cfg_err_o    <= err_d;
            cfg_rdata_o  <= rdata_d;
            clk_sel_o    <= csel_d;
            boot_done_o  <= bd_d;
            lock_err_o   <= le_d;
            if (state == S_REL && state_d == S_BOOT) boot_idx <= 1'b1;
            // counters restart on every state change and saturate at their timeout
            if (state_d != state)    ack_cnt <= '0;
            else if (ack_cnt != ACK_MAX) ack_cnt <= ack_cnt + ACNT_W'(1);
            if (state_d != state)      lock_cnt <= '0;
            else if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_cmd)                          rd_cap <= 32'h0;
        else if (state == S_REQ && ack_s && fll_wrn_o) rd_cap <= fll_r_data_i;
    end

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Directed bench for fll_cfg_ctrl: a cycle-indexed expectation table built from the timing
// rules is compared against the DUT every cycle, plus hand-computed spot values.
module tb_fll_cfg_ctrl;

    localparam int          N      = 160;
    localparam int          ACK_TO = 8;
    localparam logic [31:0] CFG1   = 32'h1234_5678;
    localparam logic [31:0] CFG2   = 32'hCAFE_0001;
    localparam logic [31:0] FLL_RD = 32'hDEAD_BEEF;

    typedef struct {
        logic        req, rv, err, csel, bd, le, gnt, wrn;
        logic [1:0]  add;
        logic [31:0] data, rdata;
    } exp_t;

    exp_t exp_tab[N];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0, cfg_we = 1'b0, cfg_relock = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_wdata = 32'h0;
    logic        fll_lock = 1'b0, loop_en = 1'b1;
    logic [31:0] fll_r_data = FLL_RD;
    logic        cfg_gnt, cfg_rvalid, cfg_err, fll_req, fll_wrn, fll_ack, clk_sel, boot_done, lock_err;
    logic [1:0]  fll_add;
    logic [31:0] cfg_rdata, fll_data;

    logic        nb_cfg_req = 1'b0;
    logic        nb_gnt, nb_rvalid, nb_err, nb_req, nb_wrn, nb_csel, nb_bd, nb_le;
    logic [1:0]  nb_add;
    logic [31:0] nb_rdata, nb_data;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    assign fll_ack = loop_en ? fll_req : 1'b0;

    fll_cfg_ctrl #(
        .BOOT_EN(1'b1), .BOOT_CFG1(CFG1), .BOOT_CFG2(CFG2),
        .LOCK_TIMEOUT(16), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_relock_i(cfg_relock), .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid),
        .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .fll_req_o(fll_req), .fll_wrn_o(fll_wrn), .fll_add_o(fll_add), .fll_data_o(fll_data),
        .fll_ack_i(fll_ack), .fll_r_data_i(fll_r_data), .fll_lock_i(fll_lock),
        .clk_sel_o(clk_sel), .boot_done_o(boot_done), .lock_err_o(lock_err)
    );

    fll_cfg_ctrl #(
        .BOOT_EN(1'b0), .BOOT_CFG1(CFG1), .BOOT_CFG2(CFG2),
        .LOCK_TIMEOUT(16), .ACK_TIMEOUT(ACK_TO)
    ) u_nb (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(nb_cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_relock_i(1'b0), .cfg_gnt_o(nb_gnt), .cfg_rvalid_o(nb_rvalid),
        .cfg_rdata_o(nb_rdata), .cfg_err_o(nb_err),
        .fll_req_o(nb_req), .fll_wrn_o(nb_wrn), .fll_add_o(nb_add), .fll_data_o(nb_data),
        .fll_ack_i(nb_req), .fll_r_data_i(fll_r_data), .fll_lock_i(fll_lock),
        .clk_sel_o(nb_csel), .boot_done_o(nb_bd), .lock_err_o(nb_le)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural model: expected outputs per cycle ----------------
    task automatic m_xfer(input int c, input int len, input logic [1:0] a, input logic [31:0] d, input logic w);
        for (int i = c; i < c + len; i++) begin
            exp_tab[i].req  = 1'b1;
            exp_tab[i].add  = a;
            exp_tab[i].data = d;
            exp_tab[i].wrn  = w;
        end
    endtask

    // boot released in cycle b: two 3-cycle write handshakes, 4 cycles apart
    task automatic m_boot(input int b);
        m_xfer(b + 1, 3, 2'd1, CFG1, 1'b0);
        m_xfer(b + 8, 3, 2'd2, CFG2, 1'b0);
    endtask

    task automatic m_bus(input int g, input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input logic ack_ok);
        exp_tab[g].gnt = 1'b1;
        if (ack_ok) begin
            m_xfer(g + 1, 3, a, wd, !we);
            exp_tab[g + 7].rv    = 1'b1;
            exp_tab[g + 7].rdata = we ? 32'h0 : FLL_RD;
        end else begin
            m_xfer(g + 1, ACK_TO, a, wd, !we);
            exp_tab[g + ACK_TO + 1].rv  = 1'b1;
            exp_tab[g + ACK_TO + 1].err = 1'b1;
        end
    endtask

    task automatic m_sticky(input int c, input int which, input logic v);
        for (int i = c; i < N; i++) begin
            case (which)
                0:       exp_tab[i].csel = v;
                1:       exp_tab[i].bd   = v;
                default: exp_tab[i].le   = v;
            endcase
        end
    endtask

    task automatic m_reset(input int c);
        m_sticky(c, 0, 1'b0);
        m_sticky(c, 1, 1'b0);
        m_sticky(c, 2, 1'b0);
    endtask

    task automatic build_model();
        for (int i = 0; i < N; i++) begin
            exp_tab[i] = '{req: 1'b0, rv: 1'b0, err: 1'b0, csel: 1'b0, bd: 1'b0, le: 1'b0,
                           gnt: 1'b0, wrn: 1'b0, add: 2'd0, data: 32'h0, rdata: 32'h0};
        end
        m_boot(4);
        m_sticky(27, 0, 1'b1);                       // lock raised at 24, seen 3 cycles later
        m_sticky(27, 1, 1'b1);
        m_bus(30, 1'b0, 2'd3, 32'h5555_AAAA, 1'b1);
        m_bus(38, 1'b1, 2'd1, 32'hA5A5_0F0F, 1'b1);
        m_bus(48, 1'b1, 2'd2, 32'h0000_00FF, 1'b0);
        m_sticky(63, 0, 1'b0);                       // lock lost at 60
        m_sticky(63, 2, 1'b1);
        m_sticky(72, 0, 1'b1);                       // relock pulse at 70
        exp_tab[75].gnt = 1'b1;
        m_xfer(76, 2, 2'd0, 32'h1111_2222, 1'b0);    // cut short by reset at 77
        m_reset(78);
        m_boot(80);
        m_sticky(95, 0, 1'b1);
        m_sticky(95, 1, 1'b1);
        m_reset(101);
        m_boot(102);
        m_sticky(132, 1, 1'b1);                      // lock timeout: 16 cycles in LOCK from 116
        m_sticky(132, 2, 1'b1);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < N) begin
            check("fll_req", cyc, 32'(fll_req), 32'(exp_tab[cyc].req));
            check("cfg_gnt", cyc, 32'(cfg_gnt), 32'(exp_tab[cyc].gnt));
            check("cfg_rvalid", cyc, 32'(cfg_rvalid), 32'(exp_tab[cyc].rv));
            check("clk_sel", cyc, 32'(clk_sel), 32'(exp_tab[cyc].csel));
            check("boot_done", cyc, 32'(boot_done), 32'(exp_tab[cyc].bd));
            check("lock_err", cyc, 32'(lock_err), 32'(exp_tab[cyc].le));
            if (exp_tab[cyc].req) begin
                check("fll_add", cyc, 32'(fll_add), 32'(exp_tab[cyc].add));
                check("fll_data", cyc, fll_data, exp_tab[cyc].data);
                check("fll_wrn", cyc, 32'(fll_wrn), 32'(exp_tab[cyc].wrn));
            end
            if (exp_tab[cyc].rv) begin
                check("cfg_rdata", cyc, cfg_rdata, exp_tab[cyc].rdata);
                check("cfg_err", cyc, 32'(cfg_err), 32'(exp_tab[cyc].err));
            end
        end
    end

    // ---------------- directed stimulus and literal spot checks ----------------
    initial begin
        build_model();
        goto(1);
        check("rst_fll_data", cyc, fll_data, 32'h0);
        check("rst_boot_done", cyc, 32'(boot_done), 32'h0);
        check("nb_rst_boot_done", cyc, 32'(nb_bd), 32'h1);
        check("nb_rst_outs", cyc,
              32'(|{nb_rvalid, nb_rdata, nb_err, nb_req, nb_wrn, nb_add, nb_data, nb_csel, nb_le}), 32'h0);
        goto(4);
        rst = 1'b0;
        goto(5);
        check("boot1_add", cyc, 32'(fll_add), 32'h1);
        check("boot1_data", cyc, fll_data, 32'h1234_5678);
        nb_cfg_req = 1'b1;
        #1;
        check("nb_idle_gnt", cyc, 32'(nb_gnt), 32'h1);
        goto(6);
        nb_cfg_req = 1'b0;
        check("nb_req", cyc, 32'(nb_req), 32'h1);
        goto(12);
        check("boot2_add", cyc, 32'(fll_add), 32'h2);
        check("boot2_data", cyc, fll_data, 32'hCAFE_0001);
        goto(24);
        fll_lock = 1'b1;
        goto(26);
        check("clk_sel_before", cyc, 32'(clk_sel), 32'h0);
        goto(27);
        check("clk_sel_lock", cyc, 32'(clk_sel), 32'h1);
        check("boot_done_lock", cyc, 32'(boot_done), 32'h1);

        goto(30);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd3; cfg_wdata = 32'h5555_AAAA;
        #1;
        check("rd_gnt", cyc, 32'(cfg_gnt), 32'h1);
        goto(34);
        check("busy_gnt", cyc, 32'(cfg_gnt), 32'h0);
        goto(37);
        check("rd_rvalid", cyc, 32'(cfg_rvalid), 32'h1);
        check("rd_rdata", cyc, cfg_rdata, 32'hDEAD_BEEF);
        check("rd_err", cyc, 32'(cfg_err), 32'h0);
        goto(38);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'hA5A5_0F0F;
        #1;
        check("wr_gnt_g8", cyc, 32'(cfg_gnt), 32'h1);
        goto(39);
        cfg_req = 1'b0;
        goto(45);
        check("wr_rdata", cyc, cfg_rdata, 32'h0);

        goto(48);
        loop_en = 1'b0;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h0000_00FF;
        #1;
        check("to_gnt", cyc, 32'(cfg_gnt), 32'h1);
        goto(49);
        cfg_req = 1'b0;
        goto(56);
        check("to_req_last", cyc, 32'(fll_req), 32'h1);
        goto(57);
        check("to_req_drop", cyc, 32'(fll_req), 32'h0);
        check("to_err", cyc, 32'(cfg_err), 32'h1);
        goto(58);
        loop_en = 1'b1;

        goto(60);
        fll_lock = 1'b0;
        goto(62);
        check("loss_clk_sel_hold", cyc, 32'(clk_sel), 32'h1);
        goto(63);
        check("loss_clk_sel", cyc, 32'(clk_sel), 32'h0);
        check("loss_lock_err", cyc, 32'(lock_err), 32'h1);
        goto(66);
        fll_lock = 1'b1;
        goto(70);
        cfg_relock = 1'b1; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0;
        #1;
        check("relock_prio_gnt", cyc, 32'(cfg_gnt), 32'h0);
        goto(71);
        cfg_relock = 1'b0; cfg_req = 1'b0;
        goto(72);
        check("relock_clk_sel", cyc, 32'(clk_sel), 32'h1);

        goto(75);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h1111_2222;
        goto(76);
        cfg_req = 1'b0;
        goto(77);
        rst = 1'b1;
        goto(78);
        check("mid_rst_req", cyc, 32'(fll_req), 32'h0);
        check("mid_rst_data", cyc, fll_data, 32'h0);
        check("mid_rst_lock_err", cyc, 32'(lock_err), 32'h0);
        check("mid_rst_boot_done", cyc, 32'(boot_done), 32'h0);
        goto(80);
        rst = 1'b0;
        goto(95);
        check("reboot_clk_sel", cyc, 32'(clk_sel), 32'h1);

        goto(100);
        fll_lock = 1'b0;
        rst = 1'b1;
        goto(102);
        rst = 1'b0;
        goto(131);
        check("lto_lock_err_pre", cyc, 32'(lock_err), 32'h0);
        goto(132);
        check("lto_lock_err", cyc, 32'(lock_err), 32'h1);
        check("lto_boot_done", cyc, 32'(boot_done), 32'h1);
        check("lto_clk_sel", cyc, 32'(clk_sel), 32'h0);

        goto(140);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
